// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the RV32IM 5-stage core.
// Resolves branches/jumps into a one-cycle PC redirect, builds store lane
// masks and lane-replicated store data, and holds/bubbles under stall,
// flush and wrong-path squash.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned H/W access trap).
module ex_mem_stage #(
    parameter int unsigned XLEN         = 32,
    parameter logic [31:0] RESET_PC_TGT = 32'h0000_0000
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic [XLEN-1:0] ex_target,
    input  logic [XLEN-1:0] ex_pc_plus4,
    input  logic            mem_stall,
    input  logic            flush,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] mem_result,
    output logic [3:0]      mem_byte_en,
    output logic [4:0]      mem_rd,
    output logic            mem_reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic [2:0]      mem_funct3,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            misalign_trap
);

    logic            r_valid;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_result;
    logic [3:0]      r_byte_en;
    logic [4:0]      r_rd;
    logic            r_reg_write;
    logic            r_read;
    logic            r_write;
    logic [2:0]      r_funct3;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_misalign;

    logic            w_cond;
    logic            w_taken;
    logic            w_is_mem;
    logic [3:0]      w_byte_en;
    logic [XLEN-1:0] w_wdata;
    logic            w_misalign;

    assign w_is_mem = ex_mem_read | ex_mem_write;

    // Branch condition from the ALU result (XOR for EQ/NE, SLT/SLTU for the rest)
    always_comb begin
        w_cond = 1'b0;
        case (ex_funct3)
            3'b000:  w_cond = (ex_alu_result == '0);
            3'b001:  w_cond = (ex_alu_result != '0);
            3'b100,
            3'b110:  w_cond = ex_alu_result[0];
            3'b101,
            3'b111:  w_cond = ~ex_alu_result[0];
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken = ex_jump | (ex_branch & w_cond);

    // Lane mask and lane-replicated store data by access size
    always_comb begin
        w_byte_en = 4'b0000;
        w_wdata   = ex_rs2_data;
        case (ex_funct3[1:0])
            2'b00: begin
                w_byte_en = 4'(4'b0001 << ex_alu_result[1:0]);
                w_wdata   = {4{ex_rs2_data[7:0]}};
            end
            2'b01: begin
                w_byte_en = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{ex_rs2_data[15:0]}};
            end
            2'b10: begin
                w_byte_en = 4'b1111;
                w_wdata   = ex_rs2_data;
            end
            default: begin
                w_byte_en = 4'b0000;
                w_wdata   = ex_rs2_data;
            end
        endcase
        if (!w_is_mem) begin
            w_byte_en = 4'b0000;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Halfword on odd address or word off a 4-byte boundary
    assign w_misalign = w_is_mem &
                        (((ex_funct3[1:0] == 2'b01) & ex_alu_result[0]) |
                         ((ex_funct3[1:0] == 2'b10) & (ex_alu_result[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    // Pipeline register: flush > stall > squash > capture
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_valid          <= 1'b0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_result         <= '0;
            r_byte_en        <= 4'b0000;
            r_rd             <= 5'd0;
            r_reg_write      <= 1'b0;
            r_read           <= 1'b0;
            r_write          <= 1'b0;
            r_funct3         <= 3'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= XLEN'(RESET_PC_TGT);
            r_misalign       <= 1'b0;
        end else if (flush) begin
            r_valid          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_misalign       <= 1'b0;
        end else if (mem_stall) begin
            r_redirect_valid <= 1'b0;
            r_misalign       <= 1'b0;
        end else if (r_redirect_valid) begin
            r_valid          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_misalign       <= 1'b0;
        end else begin
            r_valid          <= ex_valid;
            r_redirect_valid <= ex_valid & w_taken;
            r_misalign       <= ex_valid & w_misalign;
            if (ex_valid) begin
                r_addr      <= ex_alu_result;
                r_wdata     <= w_wdata;
                r_result    <= ex_jump ? ex_pc_plus4 : ex_alu_result;
                r_byte_en   <= w_byte_en;
                r_rd        <= ex_rd;
                r_reg_write <= ex_reg_write & ~w_misalign;
                r_read      <= ex_mem_read & ~w_misalign;
                r_write     <= ex_mem_write & ~w_misalign;
                r_funct3    <= ex_funct3;
                if (w_taken) begin
                    r_redirect_pc <= ex_target;
                end
            end
        end
    end

    assign ex_ready       = ~mem_stall;
    assign mem_valid      = r_valid;
    assign mem_addr       = r_addr;
    assign mem_wdata      = r_wdata;
    assign mem_result     = r_result;
    assign mem_rd         = r_rd;
    assign mem_funct3     = r_funct3;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign misalign_trap  = r_misalign;

    // Bubbles never write registers or memory
    assign mem_reg_write  = r_valid & r_reg_write;
    assign mem_read       = r_valid & r_read;
    assign mem_write      = r_valid & r_write;
    assign mem_byte_en    = r_valid ? r_byte_en : 4'b0000;

endmodule
